// File: rtl/fasm_cfg_loader.sv
// Serial configuration loader for one FASM logic cell: frames a bitstream as
// sync word + {INIT, IS_INVERTED} payload + even parity, then commits it atomically.
module fasm_cfg_loader #(
  parameter int                    INIT_WIDTH   = 1,
  parameter int                    INV_WIDTH    = 1,
  parameter logic [7:0]            SYNC_WORD    = 8'hA5,
  parameter logic [INIT_WIDTH-1:0] INIT_DEFAULT = '0,
  parameter logic [INV_WIDTH-1:0]  INV_DEFAULT  = '0,
  parameter int                    TIMEOUT      = 255
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  CFG_EN,
  input  logic                  CFG_DIN,
  input  logic                  CFG_VALID,
  output logic                  CFG_READY,
  output logic [INIT_WIDTH-1:0] INIT,
  output logic [INV_WIDTH-1:0]  IS_INVERTED,
  output logic                  CFG_DONE,
  output logic                  CFG_ERR,
  output logic                  BUSY
);

  localparam int N      = INIT_WIDTH + INV_WIDTH;
  localparam int CW     = $clog2((N > 8) ? N : 8);
  localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TO_EN  = (TIMEOUT > 0);
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PAYLOAD, S_PARITY, S_COMMIT, S_HOLD, S_ERROR
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]           to_cnt_q, to_cnt_d;
  logic [6:0]              sync_q, sync_d;
  logic [N-1:0]            shadow_q, shadow_d;
  logic [INIT_WIDTH-1:0]   init_q, init_d;
  logic [INV_WIDTH-1:0]    inv_q, inv_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic                    ready_q, ready_d;
  logic                    accept;

  assign accept = CFG_VALID & ready_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    to_cnt_d  = to_cnt_q;
    sync_d    = sync_q;
    shadow_d  = shadow_q;
    init_d    = init_q;
    inv_d     = inv_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        to_cnt_d  = '0;
        shadow_d  = '0;
        if (CFG_EN) state_d = S_SYNC;
      end
      S_SYNC, S_PAYLOAD, S_PARITY: begin
        // Abort has priority over both an arriving bit and a timeout.
        if (!CFG_EN) begin
          state_d   = S_IDLE;
          bit_cnt_d = '0;
          to_cnt_d  = '0;
        end else if (accept) begin
          to_cnt_d = '0;
          case (state_q)
            S_SYNC: begin
              sync_d = {sync_q[5:0], CFG_DIN};
              if (bit_cnt_q == CW'(7)) begin
                bit_cnt_d = '0;
                state_d   = ({sync_q, CFG_DIN} == SYNC_WORD) ? S_PAYLOAD : S_ERROR;
              end else begin
                bit_cnt_d = bit_cnt_q + CW'(1);
              end
            end
            S_PAYLOAD: begin
              shadow_d = {shadow_q[N-2:0], CFG_DIN};
              if (bit_cnt_q == CW'(N - 1)) begin
                bit_cnt_d = '0;
                state_d   = S_PARITY;
              end else begin
                bit_cnt_d = bit_cnt_q + CW'(1);
              end
            end
            default: state_d = (CFG_DIN == ^shadow_q) ? S_COMMIT : S_ERROR;
          endcase
        end else if (TO_EN) begin
          if (to_cnt_q == TO_LAST) state_d = S_ERROR;
          else                     to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      S_COMMIT: begin
        init_d  = shadow_q[N-1:INV_WIDTH];
        inv_d   = shadow_q[INV_WIDTH-1:0];
        done_d  = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD, S_ERROR: begin
        if (!CFG_EN) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_SYNC) || (state_d == S_PAYLOAD) || (state_d == S_PARITY);
    busy_d  = (state_d != S_IDLE);
    err_d   = (state_d == S_ERROR);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
      sync_q    <= '0;
      shadow_q  <= '0;
      init_q    <= INIT_DEFAULT;
      inv_q     <= INV_DEFAULT;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      to_cnt_q  <= to_cnt_d;
      sync_q    <= sync_d;
      shadow_q  <= shadow_d;
      init_q    <= init_d;
      inv_q     <= inv_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  assign CFG_READY   = ready_q;
  assign INIT        = init_q;
  assign IS_INVERTED = inv_q;
  assign CFG_DONE    = done_q;
  assign CFG_ERR     = err_q;
  assign BUSY        = busy_q;

endmodule

// File: tb/tb_fasm_cfg_loader.sv
// Directed bench for fasm_cfg_loader: good frame, bad sync, bad parity, abort,
// timeout, stall-then-complete and asynchronous reset mid-frame.
module tb_fasm_cfg_loader;

  logic CLK = 1'b0;
  logic RST_N, CFG_EN, CFG_DIN, CFG_VALID;
  logic CFG_READY, CFG_DONE, CFG_ERR, BUSY;
  logic [0:0] INIT, IS_INVERTED;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  fasm_cfg_loader #(
    .INIT_WIDTH(1), .INV_WIDTH(1), .SYNC_WORD(8'hA5),
    .INIT_DEFAULT(1'b0), .INV_DEFAULT(1'b0), .TIMEOUT(4)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .CFG_EN(CFG_EN), .CFG_DIN(CFG_DIN),
    .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY), .INIT(INIT),
    .IS_INVERTED(IS_INVERTED), .CFG_DONE(CFG_DONE), .CFG_ERR(CFG_ERR), .BUSY(BUSY)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one bit for one rising edge; called at a falling edge.
  task automatic send_bit(input logic b);
    CFG_VALID = 1'b1;
    CFG_DIN   = b;
    @(negedge CLK);
    CFG_VALID = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic start_frame();
    CFG_EN = 1'b1;
    @(negedge CLK);
  endtask

  task automatic end_frame();
    CFG_EN = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    RST_N = 1'b0; CFG_EN = 1'b0; CFG_DIN = 1'b0; CFG_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("rst_init",  32'(INIT), 32'd0);
    chk("rst_inv",   32'(IS_INVERTED), 32'd0);
    chk("rst_flags", {28'd0, CFG_DONE, CFG_ERR, BUSY, CFG_READY}, 32'd0);

    // Good frame: A5, payload 10, parity 1.
    start_frame();
    chk("sync_ready", {30'd0, BUSY, CFG_READY}, 32'd3);
    send_byte(8'hA5);
    send_bit(1'b1); send_bit(1'b0);
    send_bit(1'b1);
    chk("commit_cycle", {29'd0, CFG_DONE, INIT, CFG_READY}, 32'd0);
    @(negedge CLK);
    chk("good_done", 32'(CFG_DONE), 32'd1);
    chk("good_out",  {30'd0, INIT, IS_INVERTED}, 32'b10);
    @(negedge CLK);
    chk("done_pulse", 32'(CFG_DONE), 32'd0);
    repeat (2) @(negedge CLK);
    chk("hold", {29'd0, BUSY, CFG_READY, CFG_DONE}, 32'b100);
    end_frame();
    chk("hold_exit", 32'(BUSY), 32'd0);

    // Bad sync word.
    start_frame();
    send_byte(8'hA4);
    chk("badsync_err", {30'd0, CFG_ERR, CFG_READY}, 32'b10);
    chk("badsync_out", {30'd0, INIT, IS_INVERTED}, 32'b10);
    @(negedge CLK);
    chk("err_held", 32'(CFG_ERR), 32'd1);
    end_frame();
    chk("err_clear", {30'd0, CFG_ERR, BUSY}, 32'd0);

    // Bad parity: payload 11 needs parity 0, send 1.
    start_frame();
    send_byte(8'hA5);
    send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b1);
    chk("badpar_err", {30'd0, CFG_ERR, CFG_DONE}, 32'b10);
    @(negedge CLK);
    chk("badpar_out", {29'd0, INIT, IS_INVERTED, CFG_DONE}, 32'b100);
    end_frame();

    // Abort: EN drops in the same cycle as a valid bit.
    start_frame();
    send_byte(8'hA5);
    send_bit(1'b0);
    CFG_EN = 1'b0;
    send_bit(1'b1);
    chk("abort_flags", {29'd0, CFG_ERR, CFG_DONE, BUSY}, 32'd0);
    chk("abort_out",   {30'd0, INIT, IS_INVERTED}, 32'b10);

    // Timeout: four idle cycles in PAYLOAD.
    start_frame();
    send_byte(8'hA5);
    send_bit(1'b0);
    repeat (3) @(negedge CLK);
    chk("to_before", {30'd0, CFG_ERR, CFG_READY}, 32'b01);
    @(negedge CLK);
    chk("to_err", {30'd0, CFG_ERR, CFG_READY}, 32'b10);
    end_frame();

    // Three-cycle stall, then frame 01 + parity 1 completes.
    start_frame();
    send_byte(8'hA5);
    send_bit(1'b0);
    repeat (3) @(negedge CLK);
    chk("stall_ok", {30'd0, CFG_ERR, CFG_READY}, 32'b01);
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge CLK);
    chk("stall_done", {29'd0, CFG_DONE, CFG_ERR, BUSY}, 32'b101);
    chk("stall_out",  {30'd0, INIT, IS_INVERTED}, 32'b01);
    end_frame();

    // Asynchronous reset in the middle of a frame.
    start_frame();
    send_byte(8'hA5);
    send_bit(1'b1);
    #1 RST_N = 1'b0;
    #1;
    chk("amid_out",   {30'd0, INIT, IS_INVERTED}, 32'd0);
    chk("amid_flags", {28'd0, CFG_DONE, CFG_ERR, BUSY, CFG_READY}, 32'd0);
    CFG_EN = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("post_rst", 32'(BUSY), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
